mmu_tlb: RTL

- Clocked, parametrised successor to the combinational 68k MMU.
- Translates the CPU virtual page (A23..A12 by default) plus function code into a physical page.
- User-mode translations are cached in a small fully-associative TLB in front of the external page-table RAM. Misses walk that RAM with a configurable latency.
- Supervisor accesses use the fixed kernel window map.
- Sits between the 68k bus interface and the physical address decoder. Drives a req/done handshake that the bus-cycle logic converts into DTACK or BERR.

---
 rtl/mmu_pkg.sv | 37 +++
 rtl/mmu_tlb_cam.sv | 57 +++++
 rtl/mmu_tlb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared constants, state encoding and the fixed supervisor window map for the
// clocked 68k MMU.
package mmu_pkg;

    localparam int          FC_SUPER     = 2;
    localparam logic [2:0]  FC_CPU_SPACE = 3'b111;

    localparam logic [1:0]  REG_RAM = 2'b00;
    localparam logic [1:0]  REG_ROM = 2'b01;
    localparam logic [1:0]  REG_IO  = 2'b10;
    localparam logic [1:0]  REG_GFX = 2'b11;

    localparam logic [31:0] RAM_BASE = 32'h0000_8000;
    localparam logic [31:0] ROM_BASE = 32'h0000_4000;
    localparam logic [31:0] IO_BASE  = 32'h0000_0300;
    localparam logic [31:0] GFX_BASE = 32'h0000_3c00 & ~32'h0000_03ff;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Kernel window map; the caller truncates the result to its PPN width.
    function automatic logic [31:0] sup_map(input logic [1:0] region, input logic [31:0] off);
        logic [31:0] r;
        r = 32'h0;
        case (region)
            REG_RAM: r = RAM_BASE | off;
            REG_ROM: r = ROM_BASE | off;
            REG_IO:  r = IO_BASE | {24'h0, off[7:0]};
            default: r = GFX_BASE | off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully-associative translation cache: tag/PPN/valid storage, parallel compare,
// round-robin fill and bulk invalidate.
module mmu_tlb_cam #(
    parameter int TAG_W   = 16,
    parameter int PPN_W   = 16,
    parameter int ENTRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             flush,
    input  logic             fill,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [PPN_W-1:0] fill_ppn,
    output logic             hit,
    output logic [PPN_W-1:0] hit_ppn
);
    localparam int PTR_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0][TAG_W-1:0] tags;
    logic [ENTRIES-1:0][PPN_W-1:0] ppns;
    logic [ENTRIES-1:0]            valid;
    logic [ENTRIES-1:0]            match;
    logic [PTR_W-1:0]              ptr;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cmp
        assign match[i] = valid[i] && (tags[i] == lookup_tag);
    end

    // A flush in the lookup cycle already counts as empty.
    assign hit = (|match) && !flush;

    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++)
            hit_ppn = hit_ppn | ({PPN_W{match[i]}} & ppns[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags  <= '0;
            ppns  <= '0;
            valid <= '0;
            ptr   <= '0;
        end else begin
            if (fill) begin
                tags[ptr]  <= fill_tag;
                ppns[ptr]  <= fill_ppn;
                valid[ptr] <= 1'b1;
                ptr        <= ptr + PTR_W'(1);
            end
            if (flush)
                valid <= '0;
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Clocked 68k MMU: kernel window map for supervisor, TLB-cached page-table
// walk for user accesses, req/done handshake toward the bus-cycle logic.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int VPN_W       = 12,
    parameter int PPN_W       = 16,
    parameter int TASK_W      = 4,
    parameter int TLB_ENTRIES = 4,
    parameter int RAM_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [VPN_W-1:0]        addr_in,
    input  logic [2:0]              fc,
    input  logic [TASK_W-1:0]       user_map,
    input  logic                    flush,
    output logic [TASK_W+VPN_W-1:0] table_ram_addr,
    output logic                    table_ram_rd,
    input  logic [PPN_W:0]          table_ram_data,
    output logic [PPN_W-1:0]        addr_out,
    output logic                    done,
    output logic                    fault
);
    localparam int TAG_W = TASK_W + VPN_W;
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   walk_flushed, walk_flushed_d;
    logic                   done_d, fault_d, rd_d;
    logic [TAG_W-1:0]       ram_addr_d;
    logic [PPN_W-1:0]       addr_d;
    logic [TAG_W-1:0]       lookup_tag;
    logic                   hit, fill;
    logic [PPN_W-1:0]       hit_ppn;
    logic [31:0]            sup_map_w;
    logic                   unused_sup_hi;

    assign lookup_tag    = {user_map, addr_in};
    assign sup_map_w     = sup_map(addr_in[VPN_W-1:VPN_W-2], 32'(addr_in[VPN_W-3:0]));
    assign unused_sup_hi = ^sup_map_w[31:PPN_W];

    mmu_tlb_cam #(.TAG_W(TAG_W), .PPN_W(PPN_W), .ENTRIES(TLB_ENTRIES)) u_cam (
        .clk       (clk),
        .reset     (reset),
        .lookup_tag(lookup_tag),
        .flush     (flush),
        .fill      (fill),
        .fill_tag  (table_ram_addr),
        .fill_ppn  (table_ram_data[PPN_W-1:0]),
        .hit       (hit),
        .hit_ppn   (hit_ppn)
    );

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        walk_flushed_d = walk_flushed | flush;
        done_d         = done;
        fault_d        = fault;
        rd_d           = table_ram_rd;
        ram_addr_d     = table_ram_addr;
        addr_d         = addr_out;
        fill           = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (fc == FC_CPU_SPACE) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end else if (fc[FC_SUPER]) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    addr_d  = sup_map_w[PPN_W-1:0];
                end else if (hit) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    addr_d  = hit_ppn;
                end else begin
                    state_d        = WALK;
                    rd_d           = 1'b1;
                    ram_addr_d     = lookup_tag;
                    cnt_d          = CNT_W'(RAM_LAT - 1);
                    walk_flushed_d = 1'b0;
                end
            end
            WALK: begin
                if (!req) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                end else if (cnt == '0) begin
                    state_d = HOLD;
                    rd_d    = 1'b0;
                    done_d  = 1'b1;
                    if (table_ram_data[PPN_W]) begin
                        addr_d = table_ram_data[PPN_W-1:0];
                        // A flush seen anywhere in the walk makes the result stale for caching.
                        fill   = !walk_flushed && !flush;
                    end else begin
                        fault_d = 1'b1;
                        addr_d  = '0;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HOLD: if (!req) begin
                state_d = IDLE;
                done_d  = 1'b0;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            walk_flushed   <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            table_ram_rd   <= 1'b0;
            table_ram_addr <= '0;
            addr_out       <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            walk_flushed   <= walk_flushed_d;
            done           <= done_d;
            fault          <= fault_d;
            table_ram_rd   <= rd_d;
            table_ram_addr <= ram_addr_d;
            addr_out       <= addr_d;
        end
    end

endmodule
